// File: rtl/dp_req_scheduler.sv
// Round-robin front end that time-shares one accumulate/select datapath.
// One request is in flight at a time: grant in IDLE, hold operands through
// EXEC while the datapath latency elapses, then present the result in RESP.
module dp_req_scheduler #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NREQ   = 4,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned DP_LAT = 1,
  parameter int unsigned ID_W   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*SEL_W-1:0]  req_sel,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  output logic [WIDTH-1:0]       dp_data_in,
  output logic [SEL_W-1:0]       dp_x,
  input  logic [WIDTH-1:0]       dp_out,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  input  logic                   rsp_ready,
  output logic                   busy,
  output logic [15:0]            ops_done
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [15:0]       ops_q, ops_d;

  logic [ID_W-1:0]   gnt;
  logic              gnt_found;
  logic              accept;

  // (base + off) mod NREQ; both operands are below NREQ so one subtract suffices.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W:0]   off);
    logic [ID_W:0] s;
    s = {1'b0, base} + off;
    if (s >= (ID_W+1)'(NREQ)) begin
      s = s - (ID_W+1)'(NREQ);
    end
    return ID_W'(s);
  endfunction

  // Round-robin search starting at ptr; descending offsets so the nearest wins.
  always_comb begin
    logic [ID_W-1:0] cand;
    gnt       = '0;
    gnt_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = wrap_add(ptr_q, (ID_W+1)'(k));
      if (req_valid[cand]) begin
        gnt       = cand;
        gnt_found = 1'b1;
      end
    end
  end

  // Ready is only offered in IDLE and never looks at the response side.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (state_q == StIdle && gnt_found) begin
      req_ready[gnt] = 1'b1;
      accept         = 1'b1;
    end
  end

  // Next-state and datapath-side register updates.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sel_d   = sel_q;
    id_d    = id_q;
    res_d   = res_q;
    ops_d   = ops_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          data_d  = req_data[gnt*WIDTH +: WIDTH];
          sel_d   = req_sel[gnt*SEL_W +: SEL_W];
          id_d    = gnt;
          ptr_d   = wrap_add(gnt, (ID_W+1)'(1));
          cnt_d   = 3'(DP_LAT);
          state_d = StExec;
        end
      end
      StExec: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          res_d   = dp_out;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          if (ops_q != 16'hFFFF) begin
            ops_d = ops_q + 16'd1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      id_q    <= '0;
      res_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      id_q    <= id_d;
      res_q   <= res_d;
      ops_q   <= ops_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    dp_data_in = data_q;
    dp_x       = sel_q;
    rsp_valid  = (state_q == StResp);
    rsp_id     = id_q;
    rsp_data   = res_q;
    busy       = (state_q != StIdle);
    ops_done   = ops_q;
  end

endmodule
